riscv_regfile_wb: RTL and testbench

- Write-back end of the operand path: holds the 32x32 integer register file and supplies rs1_data/rs2_data to the operand muxes.
- Selects the write-back source, which is one of:
  - ALU result
  - load data, aligned and extended here
  - PC+4
  - CSR read data
- Commits the selected value to rd.
- Stalls the pipeline while a load response from data memory is outstanding.

---
 rtl/riscv_constants.sv | 12 +
 rtl/riscv_regfile_wb.sv | 140 ++++++++++++++
 tb/tb_riscv_regfile_wb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - shared encodings for the RISC-V operand path
package riscv_constants;

    // Three bits wide so that encodings outside the four defined sources exist.
    typedef enum logic [2:0] {
        WB_ALU = 3'd0,
        WB_MEM = 3'd1,
        WB_PC4 = 3'd2,
        WB_CSR = 3'd3
    } wb_sel_e;

endpackage

// File: rtl/riscv_regfile_wb.sv
// rtl/riscv_regfile_wb.sv - integer register file with write-back source select and load wait
module riscv_regfile_wb
    import riscv_constants::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  wb_sel_e         wb_sel,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [2:0]      load_funct3,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            retire
);

    typedef enum logic {IDLE, WAIT_MEM} state_e;

    state_e          state;
    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      pend_rd;
    logic [2:0]      pend_f3;
    logic [1:0]      pend_off;

    logic            do_wb;
    logic            src_ok;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_off;
    logic [XLEN-1:0] ld_data;

    function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] w,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_align = {{(XLEN-8){b[7]}}, b};
            3'b100:  load_align = {{(XLEN-8){1'b0}}, b};
            3'b001:  load_align = {{(XLEN-16){h[15]}}, h};
            3'b101:  load_align = {{(XLEN-16){1'b0}}, h};
            default: load_align = w;
        endcase
    endfunction

    always_comb begin
        do_wb   = 1'b0;
        src_ok  = 1'b1;
        wr_rd   = rd_addr;
        ld_f3   = load_funct3;
        ld_off  = alu_out[1:0];
        wr_data = '0;
        stall   = 1'b0;
        if (state == WAIT_MEM) begin
            wr_rd  = pend_rd;
            ld_f3  = pend_f3;
            ld_off = pend_off;
        end
        ld_data = load_align(mem_rdata, ld_f3, ld_off);

        if (state == IDLE) begin
            do_wb = wb_valid && ((wb_sel != WB_MEM) || mem_rsp_valid);
            stall = wb_valid && (wb_sel == WB_MEM) && !mem_rsp_valid;
            case (wb_sel)
                WB_ALU:  wr_data = alu_out;
                WB_PC4:  wr_data = pc + XLEN'(4);
                WB_CSR:  wr_data = csr_rdata;
                WB_MEM:  wr_data = ld_data;
                default: src_ok  = 1'b0;
            endcase
        end else begin
            do_wb   = mem_rsp_valid;
            stall   = !mem_rsp_valid;
            wr_data = ld_data;
        end

        // A reset cycle suppresses everything, including a response landing in WAIT_MEM.
        if (rst) begin
            do_wb = 1'b0;
            stall = 1'b0;
        end
        retire = do_wb;
        wr_en  = do_wb && src_ok && (wr_rd != 5'd0);
    end

    always_comb begin
        if (rs1_addr == 5'd0)                   rs1_data = '0;
        else if (wr_en && (wr_rd == rs1_addr))  rs1_data = wr_data;
        else                                    rs1_data = regs[rs1_addr];

        if (rs2_addr == 5'd0)                   rs2_data = '0;
        else if (wr_en && (wr_rd == rs2_addr))  rs2_data = wr_data;
        else                                    rs2_data = regs[rs2_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            state    <= IDLE;
            pend_rd  <= '0;
            pend_f3  <= '0;
            pend_off <= '0;
        end else begin
            if (wr_en) regs[wr_rd] <= wr_data;
            case (state)
                IDLE: begin
                    if (wb_valid && (wb_sel == WB_MEM) && !mem_rsp_valid) begin
                        pend_rd  <= rd_addr;
                        pend_f3  <= load_funct3;
                        pend_off <= alu_out[1:0];
                        state    <= WAIT_MEM;
                    end
                end
                default: begin
                    if (mem_rsp_valid) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_regfile_wb.sv
// tb/tb_riscv_regfile_wb.sv - scoreboard bench for riscv_regfile_wb
module tb_riscv_regfile_wb;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid = 1'b0;
    wb_sel_e     wb_sel = WB_ALU;
    logic [31:0] alu_out = '0, pc = '0, csr_rdata = '0, mem_rdata = '0;
    logic [2:0]  load_funct3 = '0;
    logic        mem_rsp_valid = 1'b0;
    logic        stall, retire;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    riscv_regfile_wb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .rd_addr(rd_addr),
        .alu_out(alu_out), .pc(pc), .csr_rdata(csr_rdata),
        .load_funct3(load_funct3), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .stall(stall), .retire(retire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  begin sh = w >> (16 * off[1]); return 32'($signed(sh[15:0])); end
            3'b101:  begin sh = w >> (16 * off[1]); return {16'h0, sh[15:0]}; end
            default: return w;
        endcase
    endfunction

    // Single-cycle write-back (loads answered in the same cycle).
    task automatic issue(input string tag, input wb_sel_e sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pcv, input logic [31:0] csr,
                         input logic [2:0] f3, input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] v;
        logic        wr;
        wr = 1'b1;
        case (sel)
            WB_ALU:  v = alu;
            WB_PC4:  v = pcv + 32'd4;
            WB_CSR:  v = csr;
            WB_MEM:  v = ref_load(rdata, f3, alu[1:0]);
            default: begin v = 32'h0; wr = 1'b0; end
        endcase
        if (rd == 5'd0 || !wr) v = model[rd];
        wb_valid = 1'b1; wb_sel = sel; rd_addr = rd; alu_out = alu; pc = pcv;
        csr_rdata = csr; load_funct3 = f3; mem_rdata = rdata;
        mem_rsp_valid = (sel == WB_MEM); rs1_addr = rd;
        sb.push_back('{rd: rd, data: v});
        @(negedge clk);
        check({tag, " retire"}, 32'(retire), 32'd1);
        check({tag, " stall"}, 32'(stall), 32'd0);
        e = sb.pop_front();
        check({tag, " bypass"}, rs1_data, e.data);
        model[e.rd] = e.data;
        @(posedge clk); #1;
        wb_valid = 1'b0; mem_rsp_valid = 1'b0; rs2_addr = rd;
        #1 check({tag, " array"}, rs2_data, model[rd]);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            #1 check($sformatf("%s x%0d", tag, i), rs1_data, model[i]);
        end
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset retire", 32'(retire), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check_all_regs("reset");

        issue("alu x0", WB_ALU, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b010, 32'h0);
        issue("alu x5", WB_ALU, 5'd5, 32'h12345678, 32'h0, 32'h0, 3'b010, 32'h0);
        issue("pc4 wrap", WB_PC4, 5'd1, 32'h0, 32'hFFFFFFFC, 32'h0, 3'b010, 32'h0);
        issue("pc4", WB_PC4, 5'd8, 32'h0, 32'h00001000, 32'h0, 3'b010, 32'h0);
        issue("csr x2", WB_CSR, 5'd2, 32'h0, 32'h0, 32'hA5A5A5A5, 3'b010, 32'h0);
        issue("bad sel", wb_sel_e'(3'd5), 5'd2, 32'h11111111, 32'h0, 32'h22222222, 3'b010, 32'h0);

        issue("lb off3", WB_MEM, 5'd10, 32'h00000103, 32'h0, 32'h0, 3'b000, 32'h80FF7F01);
        issue("lbu off3", WB_MEM, 5'd11, 32'h00000103, 32'h0, 32'h0, 3'b100, 32'h80FF7F01);
        issue("lb off0", WB_MEM, 5'd12, 32'h00000100, 32'h0, 32'h0, 3'b000, 32'h80FF7F01);
        issue("lh off2", WB_MEM, 5'd13, 32'h00000102, 32'h0, 32'h0, 3'b001, 32'h80FF7F01);
        issue("lhu off2", WB_MEM, 5'd14, 32'h00000102, 32'h0, 32'h0, 3'b101, 32'h80FF7F01);
        issue("lh off3", WB_MEM, 5'd15, 32'h00000103, 32'h0, 32'h0, 3'b001, 32'h80FF7F01);
        issue("lh off0", WB_MEM, 5'd16, 32'h00000100, 32'h0, 32'h0, 3'b001, 32'h80FF7F01);
        issue("lw off1", WB_MEM, 5'd17, 32'h00000101, 32'h0, 32'h0, 3'b010, 32'h80FF7F01);
        issue("f3 011", WB_MEM, 5'd18, 32'h00000103, 32'h0, 32'h0, 3'b011, 32'h80FF7F01);
        issue("lb x0", WB_MEM, 5'd0, 32'h00000103, 32'h0, 32'h0, 3'b000, 32'h80FF7F01);

        // Load to x7 with a three-cycle memory delay; request inputs are scrambled while waiting.
        wb_valid = 1'b1; wb_sel = WB_MEM; rd_addr = 5'd7; alu_out = 32'h00002000;
        load_funct3 = 3'b010; mem_rsp_valid = 1'b0; rs1_addr = 5'd7;
        sb.push_back('{rd: 5'd7, data: 32'hCAFEF00D});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("wait stall c%0d", c), 32'(stall), 32'd1);
            check($sformatf("wait retire c%0d", c), 32'(retire), 32'd0);
            @(posedge clk); #1;
            wb_sel = WB_ALU; rd_addr = 5'd9; alu_out = 32'h13572467; load_funct3 = 3'b000;
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rsp stall", 32'(stall), 32'd0);
        check("rsp retire", 32'(retire), 32'd1);
        e = sb.pop_front();
        check("rsp bypass", rs1_data, e.data);
        model[e.rd] = e.data;
        @(posedge clk); #1;
        wb_valid = 1'b0; mem_rsp_valid = 1'b0; rs2_addr = 5'd7; rs1_addr = 5'd9;
        #1;
        check("rsp array x7", rs2_data, model[7]);
        check("wait ignored x9", rs1_data, model[9]);

        // Reset lands in WAIT_MEM together with the response.
        wb_valid = 1'b1; wb_sel = WB_MEM; rd_addr = 5'd3; alu_out = 32'h0; load_funct3 = 3'b010;
        mem_rsp_valid = 1'b0;
        sb.push_back('{rd: 5'd3, data: 32'h55AA55AA});
        @(negedge clk);
        check("pre-rst stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        wb_valid = 1'b0; rst = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        check("rst-wait retire", 32'(retire), 32'd0);
        check("rst-wait stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_rsp_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1 check("post-rst stall", 32'(stall), 32'd0);
        check_all_regs("post-rst");
        issue("post-rst alu", WB_ALU, 5'd4, 32'h0BADF00D, 32'h0, 32'h0, 3'b010, 32'h0);

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
